// File: rtl/channel_scanner.sv
// channel_scanner: N-channel time-division scanner with programmable dwell, single-step mode,
// freeze enable and a per-frame snapshot of all channel samples.
module channel_scanner #(
  parameter int N_CH = 4,
  parameter int DWELL = 1,
  localparam int SEL_W = N_CH > 2 ? $clog2(N_CH) : 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             MODE,
  input  logic             STEP,
  input  logic [N_CH-1:0]  I,
  output logic [N_CH-1:0]  Y,
  output logic [SEL_W-1:0] SEL,
  output logic [N_CH-1:0]  FRAME,
  output logic             FRAME_VLD
);
  localparam int CNT_W = DWELL > 1 ? $clog2(DWELL) : 1;
  logic [CNT_W-1:0] cnt;
  logic [N_CH-1:0] shadow;
  logic adv, last;
  always_comb begin
    last = SEL == SEL_W'(N_CH - 1);
    adv = MODE ? STEP : cnt == CNT_W'(DWELL - 1);
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      SEL <= '0;
      cnt <= '0;
      Y <= '0;
      FRAME <= '0;
      FRAME_VLD <= 1'b0;
      shadow <= '0;
    end else begin
      FRAME_VLD <= 1'b0;
      if (EN) begin
        Y <= I[SEL] ? N_CH'(1) << SEL : '0;
        // step mode parks the dwell counter at 0 so a return to auto starts a fresh dwell
        cnt <= MODE || adv ? '0 : cnt + 1'b1;
        if (adv) begin
          shadow[SEL] <= I[SEL];
          SEL <= last ? '0 : SEL + 1'b1;
        end
        if (adv && last) begin
          FRAME <= {I[N_CH-1], shadow[N_CH-2:0]};
          FRAME_VLD <= 1'b1;
        end
      end
    end
  end
endmodule

// File: doc/channel_scanner.md
Name: channel_scanner

Overview:
Parametrised time-division channel scanner. It is the N-channel successor of the fixed 4-channel counter/mux/decoder/latch datapath. An internal channel counter walks the N_CH input bits. Each selected bit is routed to its own position on a registered one-hot-gated output. The block adds programmable dwell per channel, a single-step mode, a freeze enable, and a per-frame snapshot of all channels with a valid strobe. It sits between raw input pins and downstream display/latch logic.

Parameters:
- N_CH, 4: number of input channels; must be ≥2; need not be a power of 2.
- DWELL, 1: clock cycles spent on each channel in auto mode; must be ≥1.
- SEL_W (localparam): max(1, clog2(N_CH)); width of the channel index.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST  input  1  synchronous, active-high reset.
- EN  input  1  scan enable; 0 freezes all state.
- MODE  input  1  0 = auto scan (dwell-timed), 1 = single-step.
- STEP  input  1  advance request in step mode; level-sampled, 1 advance per cycle it is high.
- I  input  N_CH  channel inputs.
- Y  output  N_CH  registered output: only bit SEL may be 1, and it equals I[SEL].
- SEL  output  SEL_W  current channel index (registered).
- FRAME  output  N_CH  snapshot of all channel samples from the last completed frame.
- FRAME_VLD  output  1  one-cycle pulse, coincident with a FRAME update.

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous and active-high, and has priority over everything else.
- Reset values: SEL=0, dwell counter=0, Y=0, FRAME=0, FRAME_VLD=0, shadow register=0.
- RST asserted mid-frame discards the partial shadow. There is no FRAME_VLD for the aborted frame.
- Y path: with EN=1, Y <= one-hot(SEL) & {N_CH{I[SEL]}}. Latency is 1 cycle from SEL/I to Y.
- With EN=0: SEL, dwell counter, shadow and Y all hold. FRAME_VLD is 0.
- Advance condition:
  - Auto mode (MODE=0, EN=1): the dwell counter increments every cycle. When it equals DWELL-1, it clears to 0 and an advance occurs. With DWELL=1 an advance occurs every cycle.
  - Step mode (MODE=1, EN=1): the dwell counter is held at 0. An advance occurs on each cycle with STEP=1.
- On advance:
  - shadow[SEL] <= I[SEL].
  - SEL <= (SEL==N_CH-1) ? 0 : SEL+1. The wrap is explicit, so values ≥N_CH are never reached.
- Frame completion (advance while SEL==N_CH-1): on the same edge, FRAME <= shadow with bit N_CH-1 replaced by I[N_CH-1], and FRAME_VLD <= 1. Otherwise FRAME_VLD <= 0. FRAME holds until the next completion.
- Mode switch: an auto→step transition clears the dwell counter on that edge, so a partial dwell is discarded. A step→auto transition starts a fresh dwell from 0. Neither switch moves SEL.
- In auto mode STEP is ignored. With EN=0, STEP is ignored in both modes.
- Simultaneous RST with EN/STEP: reset wins.
- No combinational path from inputs to outputs. All outputs are flops.

Test Plan:
1. N_CH=4, DWELL=3, MODE=0, EN=1, I=4'b1010 from reset release (cycle 0):
   - SEL = 0,0,0,1,1,1,2,2,2,3,3,3,0…
   - Y = 0000 during channel 0, 0010 one cycle after SEL becomes 1, 0000 for channel 2, 1000 for channel 3.
   - FRAME_VLD=1 only in cycle 12, with FRAME=1010.
2. Same setup, but drop EN to 0 for cycles 4–7:
   - SEL stays 1, and Y holds 0010.
   - The scan then resumes with the remaining dwell count intact.
   - The first FRAME_VLD moves to cycle 16.
3. Step mode, N_CH=4, I=4'b0110, STEP pulsed 4 times with idle gaps:
   - SEL = 1,2,3,0 after each pulse.
   - FRAME_VLD pulses once, after the 4th STEP, with FRAME=0110.
   - Holding STEP high for 3 cycles gives 3 advances.
4. N_CH=5, DWELL=1, I=5'b10001:
   - SEL sequence 0,1,2,3,4,0 (never 5–7).
   - FRAME_VLD every 5 cycles, with FRAME=10001.
5. Assert RST in cycle 7 of scenario 1:
   - Next cycle: all outputs 0 and SEL=0.
   - No FRAME_VLD until 12 cycles after release.
6. Switch MODE 0→1 on the 2nd dwell cycle of channel 1, then back to 0:
   - The partial dwell is discarded and SEL stays 1.
   - After returning to auto, channel 1 occupies a full 3 cycles.
